fib_seq_ctrl: RTL and testbench
===============================

Name: fib_seq_ctrl

Overview:
- Sequential control/datapath stage of the hierarchical Fibonacci generator; wraps the 4-bit ripple-carry adder stage.
- Holds the two most recent terms and drives them onto the adder operands. Consumes the adder sum and carry-out to advance the sequence.
- Streams terms F(0), F(1), ... to a downstream consumer over a valid/ready handshake, for a programmable number of terms.
- Flags 4-bit overflow when a term that must be emitted does not fit in 4 bits.

Parameters:
- CNT_W, 5, width of the term-count input and the term index (max 2^CNT_W-1 terms per run).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- n_terms  input  CNT_W  number of terms to emit; latched on an accepted start.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- out_valid  output  1  fib_out holds a valid term.
- out_ready  input  1  downstream accepts the term.
- fib_out  output  4  current term value.
- term_idx  output  CNT_W  index k of the term on fib_out (F(k)).
- done  output  1  one-cycle pulse when the run ends.
- overflow  output  1  sticky; run truncated by 4-bit overflow. Cleared on the next accepted start.
- add_a  output  4  adder operand A; combinationally equals prev.
- add_b  output  4  adder operand B; combinationally equals curr.
- add_sum  input  4  adder sum (add_a + add_b, carry-in 0). Combinational from add_a/add_b.
- add_cout  input  1  adder carry-out.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; prev=0, curr=0, term_idx=0, remaining=0, ovf_pending=0. Outputs busy=0, out_valid=0, fib_out=0, done=0, overflow=0.
- States are IDLE, EMIT, DONE.
- IDLE, start=1 at edge t:
  - prev<=0, curr<=1, term_idx<=0, remaining<=n_terms, overflow<=0, ovf_pending<=0.
  - If n_terms=0, go to DONE. Otherwise go to EMIT; out_valid=1 first at cycle t+1 (latency 1).
- EMIT:
  - out_valid=1, fib_out=prev.
  - fib_out and term_idx are held stable while out_valid && !out_ready.
  - Handshake occurs at an edge with out_valid && out_ready.
- On a handshake in EMIT:
  - remaining<=remaining-1, term_idx<=term_idx+1.
  - prev<=curr, curr<=add_sum. The sum is term idx+2.
  - If remaining==1 (last term), or ovf_pending==1: go to DONE.
  - Else if add_cout==1 and remaining>=3 (term idx+2 would be emitted): ovf_pending<=1, overflow<=1. Term idx+1 is still emitted, then the run ends.
  - Carry-out on a sum that is never emitted (remaining<=2) is ignored; no overflow.
- DONE:
  - Lasts exactly one cycle: done=1, out_valid=0, busy=1. Then go to IDLE.
  - overflow persists into IDLE until the next accepted start.
- start while busy is ignored; n_terms changes after the start edge have no effect.
- Arithmetic is 4-bit unsigned and never wraps into emitted data. Largest emitted value is F(7)=13; F(8)=21 sets overflow.
- A maximal non-overflow run is n_terms=8, emitting 0,1,1,2,3,5,8,13 with no overflow. Computing F(8) occurs only at the handshake of F(6) with remaining=2.
- Reset mid-run aborts immediately to the reset values. No done pulse is issued.

Test Plan:
- Reset/idle: rst_n low, then high, no start -> all outputs 0. add_a=add_b=0 held. done never pulses.
- Basic run: n_terms=6, out_ready=1 -> out_valid from cycle after start for 6 consecutive cycles. fib_out=0,1,1,2,3,5; term_idx=0..5. done pulses on cycle 7 after start; overflow=0.
- Backpressure: n_terms=4, out_ready toggled 1,0,0,1,1,0,1 -> each value held stable while ready=0. Output sequence 0,1,1,2 exactly once each; done after the last handshake.
- Overflow: n_terms=12, out_ready=1 -> emits 0,1,1,2,3,5,8,13 (8 terms). overflow=1 rises at the F(6) handshake. done follows F(7), and overflow stays 1 in IDLE. Exact fit with n_terms=8 -> same 8 terms, overflow=0.
- Edge counts: n_terms=0 -> no out_valid, done one cycle after start, busy high only that cycle. n_terms=1 -> single term 0, then done.
- Async abort and restart: assert rst_n low mid-run with out_valid=1 -> outputs zero immediately, no done. start asserted during EMIT is ignored. Restart with n_terms=3 after overflow -> overflow clears at start; emits 0,1,1.

Source files
------------

// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequence controller: holds the last two terms, drives the external
// 4-bit adder and streams F(0), F(1), ... over a valid/ready handshake.
module fib_seq_ctrl #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       fib_out,
  output logic [CNT_W-1:0] term_idx,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_prev;
  logic [3:0]       r_curr;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_rem;
  logic             r_ovf_pend;
  logic             r_ovf;

  logic w_start;
  logic w_hs;
  logic w_last;
  logic w_ovf_hit;

  assign w_start = (r_state == S_IDLE) && start;
  assign w_hs    = (r_state == S_EMIT) && out_ready;
  assign w_last  = (r_rem == CNT_W'(1));

  // Carry only matters when the overflowing sum would itself be emitted.
  assign w_ovf_hit = w_hs && !w_last && !r_ovf_pend && add_cout &&
                     (r_rem >= CNT_W'(3));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (n_terms == '0) ? S_DONE : S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_hs && (w_last || r_ovf_pend)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_prev     <= '0;
      r_curr     <= '0;
      r_idx      <= '0;
      r_rem      <= '0;
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_prev     <= '0;
        r_curr     <= 4'd1;
        r_idx      <= '0;
        r_rem      <= n_terms;
        r_ovf      <= 1'b0;
        r_ovf_pend <= 1'b0;
      end else if (w_hs) begin
        r_rem  <= r_rem - CNT_W'(1);
        r_idx  <= r_idx + CNT_W'(1);
        r_prev <= r_curr;
        r_curr <= add_sum;
        if (w_ovf_hit) begin
          r_ovf_pend <= 1'b1;
          r_ovf      <= 1'b1;
        end
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_EMIT);
  assign done      = (r_state == S_DONE);
  assign fib_out   = r_prev;
  assign term_idx  = r_idx;
  assign overflow  = r_ovf;
  assign add_a     = r_prev;
  assign add_b     = r_curr;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Testbench for fib_seq_ctrl: directed and randomized runs checked against a
// Fibonacci reference computed with plain integer arithmetic.
module tb_fib_seq_ctrl;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] n_terms;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       fib_out;
  logic [CNT_W-1:0] term_idx;
  logic             done;
  logic             overflow;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic [3:0]       add_sum;
  logic             add_cout;

  int vectors     = 0;
  int miscompares = 0;

  fib_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .n_terms  (n_terms),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fib_out  (fib_out),
    .term_idx (term_idx),
    .done     (done),
    .overflow (overflow),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // Behavioural stand-in for the ripple-carry adder stage.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fib(input int k);
    int a = 0;
    int b = 1;
    int t;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // mode 0: ready always 1; mode 1: random ready; mode 2: fixed ready pattern
  task automatic run(input int n, input int mode);
    int cnt;
    int acc;
    int pat_i;
    bit ovf;
    bit fin;
    bit rdy;
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    cnt = 0;
    while (cnt < n && fib(cnt) < 16) cnt++;
    ovf = (cnt < n);
    start     = 1'b1;
    n_terms   = CNT_W'(n);
    out_ready = 1'b0;
    @(posedge clk); #1;
    start   = 1'b0;
    n_terms = CNT_W'($urandom);
    acc   = 0;
    pat_i = 0;
    fin   = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      chk("busy", busy, 1);
      chk("overflow", overflow, (ovf && acc >= cnt - 1));
      if (done) begin
        chk("done_count", acc, cnt);
        chk("done_valid", out_valid, 0);
        fin       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
      end else begin
        chk("valid", out_valid, 1);
        chk("fib_out", fib_out, fib(acc));
        chk("term_idx", term_idx, acc);
        if (mode == 0)      rdy = 1'b1;
        else if (mode == 1) rdy = 1'($urandom_range(0, 1));
        else                rdy = 1'(pat[pat_i % 7]);
        pat_i++;
        out_ready = rdy;
        start     = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (rdy) acc++;
      end
    end
    if (!fin) chk("timeout", 0, 1);
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_overflow", overflow, ovf);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    n_terms   = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_fib", fib_out, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_idx", term_idx, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("idle_nodone", done, 0);
      chk("idle_add_a", add_a, 0);
      chk("idle_add_b", add_b, 0);
      @(posedge clk); #1;
    end

    run(6, 0);
    run(4, 2);
    run(12, 0);
    run(8, 0);
    run(0, 0);
    run(1, 0);

    // Asynchronous abort mid-run
    start   = 1'b1;
    n_terms = CNT_W'(12);
    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("abort_pre_valid", out_valid, 1);
    chk("abort_pre_fib", fib_out, fib(3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_fib", fib_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_idx", term_idx, 0);
    chk("abort_done", done, 0);
    #4;
    rst_n     = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("abort_after_done", done, 0);

    run(12, 0);
    run(3, 0);

    for (int i = 0; i < 20; i++) run($urandom_range(0, 12), 1);
    for (int i = 0; i < 5; i++) run($urandom_range(0, 31), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
